// File: rtl/bs_host_if.sv
// bs_host_if: host register interface that sequences a command/status handshake with a processor
module bs_host_if #(
   parameter int TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        irq,
   output logic [31:0] constK,
   output logic [31:0] const1,
   output logic [31:0] const2,
   output logic [31:0] const3,
   output logic [3:0]  cmd,
   input  logic [3:0]  status,
   input  logic [31:0] dout
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, DONE, ERR} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] k_q, k_d, c1_q, c1_d, c2_q, c2_d, c3_q, c3_d, result_q, result_d;
   logic [31:0] rdata_q, rdata_d, rmux, stat;
   logic rvalid_q, rvalid_d, busy, done, err, start, clr, stat_rd;
   always_comb begin
      busy = state_q inside {ISSUE, WAIT, ACK};
      done = state_q == DONE;
      err = state_q == ERR;
      start = wr_en && addr == 4'd0 && wdata[0];
      clr = wr_en && addr == 4'd0 && wdata[1];
      stat_rd = rd_en && addr == 4'd1;
      stat = {24'd0, status, 1'b0, err, done, busy};
      k_d = (wr_en && !busy && addr == 4'd2) ? wdata : k_q;
      c1_d = (wr_en && !busy && addr == 4'd3) ? wdata : c1_q;
      c2_d = (wr_en && !busy && addr == 4'd4) ? wdata : c2_q;
      c3_d = (wr_en && !busy && addr == 4'd5) ? wdata : c3_q;
      case (addr)
         4'd1:    rmux = stat;
         4'd2:    rmux = k_q;
         4'd3:    rmux = c1_q;
         4'd4:    rmux = c2_q;
         4'd5:    rmux = c3_q;
         4'd6:    rmux = result_q;
         default: rmux = '0;
      endcase
      rdata_d = rd_en ? rmux : '0;
      rvalid_d = rd_en;
      state_d = state_q;
      cnt_d = cnt_q;
      result_d = result_q;
      case (state_q)
         IDLE:  state_d = start ? ISSUE : IDLE;
         ISSUE: begin
            if (status == 4'd1) begin
               state_d = WAIT;
               cnt_d = '0;
            end
         end
         WAIT: begin
            if (status == 4'd2) begin
               state_d = ACK;
               result_d = dout;
            end else if (cnt_q == CW'(TIMEOUT - 1)) state_d = ERR;
            else cnt_d = cnt_q + 1'b1;
         end
         ACK:   state_d = (status == 4'd0) ? DONE : ACK;
         DONE:  state_d = start ? ISSUE : stat_rd ? IDLE : DONE;
         ERR:   state_d = clr ? IDLE : ERR;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         k_q <= '0;
         c1_q <= '0;
         c2_q <= '0;
         c3_q <= '0;
         result_q <= '0;
         rdata_q <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         k_q <= k_d;
         c1_q <= c1_d;
         c2_q <= c2_d;
         c3_q <= c3_d;
         result_q <= result_d;
         rdata_q <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end
   assign cmd = state_q == ISSUE ? 4'd1 : state_q == ACK ? 4'd2 : 4'd0;
   assign irq = done | err;
   assign rdata = rdata_q;
   assign rvalid = rvalid_q;
   assign constK = k_q;
   assign const1 = c1_q;
   assign const2 = c2_q;
   assign const3 = c3_q;
endmodule

// File: tb/tb_bs_host_if.sv
// tb_bs_host_if: directed checks of the host interface with TIMEOUT=16 and a hand-driven processor
module tb_bs_host_if;
   logic clk = 1'b0, nreset = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [3:0] addr = '0, cmd, status = '0;
   logic [31:0] wdata = '0, rdata, dout = '0, constK, const1, const2, const3;
   logic rvalid, irq;
   int vectors = 0, errs = 0;
   bs_host_if #(.TIMEOUT(16)) dut (
      .clk(clk), .nreset(nreset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
      .rdata(rdata), .rvalid(rvalid), .irq(irq), .constK(constK), .const1(const1),
      .const2(const2), .const3(const3), .cmd(cmd), .status(status), .dout(dout)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      wr_en = 1'b1;
      addr = a;
      wdata = d;
      tick();
      wr_en = 1'b0;
   endtask
   task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
      rd_en = 1'b1;
      addr = a;
      tick();
      rd_en = 1'b0;
      chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
      chk(tag, rdata, exp);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      #2;
      chk("rst_cmd", {28'd0, cmd}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_constK", constK, 32'd0);
      tick();
      tick();
      nreset = 1'b1;
      tick();
      wr(4'h2, 32'h64);
      wr(4'h3, 32'h1);
      wr(4'h4, 32'h2);
      wr(4'h5, 32'h3);
      chk("constK", constK, 32'h64);
      chk("const1", const1, 32'h1);
      chk("const2", const2, 32'h2);
      chk("const3", const3, 32'h3);
      // normal run: cmd 1, 0, 2, 0
      wr(4'h0, 32'h1);
      chk("run_issue_cmd", {28'd0, cmd}, 32'd1);
      rd("run_stat_busy", 4'h1, 32'h01);
      status = 4'd1;
      tick();
      chk("run_wait_cmd", {28'd0, cmd}, 32'd0);
      wr(4'h2, 32'h55);
      rd("lock_k", 4'h2, 32'h64);
      chk("lock_constK", constK, 32'h64);
      status = 4'd2;
      dout = 32'h1234;
      tick();
      chk("run_ack_cmd", {28'd0, cmd}, 32'd2);
      tick();
      chk("run_ack_hold", {28'd0, cmd}, 32'd2);
      status = 4'd0;
      tick();
      chk("run_done_cmd", {28'd0, cmd}, 32'd0);
      chk("run_done_irq", {31'd0, irq}, 32'd1);
      rd("run_result", 4'h6, 32'h1234);
      tick();
      chk("rvalid_one_cycle", {31'd0, rvalid}, 32'd0);
      rd("run_stat_done", 4'h1, 32'h02);
      chk("stat_rd_clears_irq", {31'd0, irq}, 32'd0);
      rd("rd_unmapped", 4'hF, 32'h0);
      rd("rd_ctrl", 4'h0, 32'h0);
      wr_en = 1'b1;
      rd_en = 1'b1;
      addr = 4'h2;
      wdata = 32'hAA;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("rw_same_prewrite", rdata, 32'h64);
      chk("rw_same_constK", constK, 32'hAA);
      wr(4'h6, 32'hDEAD);
      rd("wr_result_ignored", 4'h6, 32'h1234);
      // timeout: 16 WAIT cycles with status stuck at RUNNING
      status = 4'd1;
      wr(4'h0, 32'h1);
      tick();
      for (int i = 0; i < 15; i++) tick();
      chk("to_wait_irq", {31'd0, irq}, 32'd0);
      chk("to_wait_cmd", {28'd0, cmd}, 32'd0);
      tick();
      chk("to_err_irq", {31'd0, irq}, 32'd1);
      rd("to_stat", 4'h1, 32'h14);
      wr(4'h0, 32'h1);
      chk("err_start_cmd", {28'd0, cmd}, 32'd0);
      chk("err_start_irq", {31'd0, irq}, 32'd1);
      wr(4'h0, 32'h3);
      chk("clr_irq", {31'd0, irq}, 32'd0);
      chk("clr_cmd", {28'd0, cmd}, 32'd0);
      rd("clr_stat", 4'h1, 32'h10);
      // completion on the exact timeout cycle wins
      wr(4'h0, 32'h1);
      tick();
      for (int i = 0; i < 15; i++) tick();
      status = 4'd2;
      dout = 32'hBEEF;
      tick();
      chk("bnd_ack_cmd", {28'd0, cmd}, 32'd2);
      chk("bnd_irq", {31'd0, irq}, 32'd0);
      status = 4'd0;
      tick();
      chk("bnd_done_irq", {31'd0, irq}, 32'd1);
      rd("bnd_result", 4'h6, 32'hBEEF);
      chk("bnd_done_hold", {31'd0, irq}, 32'd1);
      wr(4'h0, 32'h1);
      chk("done_start_cmd", {28'd0, cmd}, 32'd1);
      chk("done_start_irq", {31'd0, irq}, 32'd0);
      status = 4'd1;
      tick();
      chk("rst_wait_cmd", {28'd0, cmd}, 32'd0);
      #2;
      nreset = 1'b0;
      #1;
      chk("arst_cmd", {28'd0, cmd}, 32'd0);
      chk("arst_constK", constK, 32'd0);
      chk("arst_const1", const1, 32'd0);
      chk("arst_irq", {31'd0, irq}, 32'd0);
      tick();
      nreset = 1'b1;
      tick();
      rd("arst_stat", 4'h1, 32'h10);
      rd("arst_result", 4'h6, 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
